// File: rtl/circuito_exp6_genius.sv
// rtl/circuito_exp6_genius.sv - Simon-style memory game: datapath, control FSM and 7-segment debug
// Optional feature macro: SHOW_SEQUENCE_EN (adds MOSTRA state that replays the sequence on leds)

module hex7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  // Active-low segments, bit order {g,f,e,d,c,b,a}
  always_comb begin
    seg = 7'b1111111;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end
endmodule

module circuito_exp6_genius #(
  parameter int TIMEOUT_CYCLES = 30000,
  parameter int MEM_DEPTH      = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] botoes,
  output logic [3:0] leds,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_clock,
  output logic       db_tem_jogada,
  output logic       db_igual,
  output logic       db_enderecoIgualRodada,
  output logic       db_timeout,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_jogadafeita,
  output logic [6:0] db_rodada,
  output logic [6:0] db_estado
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARA        = 4'h1,
    INICIA_RODADA  = 4'h2,
    ESPERA         = 4'h3,
    REGISTRA       = 4'h4,
    COMPARA        = 4'h5,
    PROXIMA        = 4'h6,
    ESPERA_NOVA    = 4'h7,
    REGISTRA_NOVA  = 4'h8,
    ESCREVE        = 4'h9,
    PROXIMA_RODADA = 4'hA,
    FIM_GANHOU     = 4'hB,
    FIM_PERDEU     = 4'hC,
    FIM_TIMEOUT    = 4'hD
`ifdef SHOW_SEQUENCE_EN
    , MOSTRA       = 4'hE
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   rodada_q, rodada_d;
  logic [AW-1:0]   endereco_q, endereco_d;
  logic [3:0]      jogada_q, jogada_d;
  logic [3:0]      mem_q [MEM_DEPTH];
  logic [3:0]      mem_d [MEM_DEPTH];
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            tem_prev_q, tem_prev_d;
  logic            pulse_q, pulse_d;
  logic [3:0]      botoes_edge_q, botoes_edge_d;
  logic            pronto_q, pronto_d;
  logic            ganhou_q, ganhou_d;
  logic            perdeu_q, perdeu_d;
  logic            tem_jogada;
  logic            timeout;
  logic [3:0]      mem_rd;
`ifdef SHOW_SEQUENCE_EN
  logic [2:0]      mostra_cnt_q, mostra_cnt_d;
`endif

  assign tem_jogada = |botoes;
  assign timeout    = (tmo_q == TMO_LAST);
  assign mem_rd     = mem_q[endereco_q];

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d       = state_q;
    rodada_d      = rodada_q;
    endereco_d    = endereco_q;
    jogada_d      = jogada_q;
    mem_d         = mem_q;
    tmo_d         = '0;
    tem_prev_d    = tem_jogada;
    pulse_d       = tem_jogada & ~tem_prev_q;
    botoes_edge_d = botoes;
`ifdef SHOW_SEQUENCE_EN
    mostra_cnt_d  = mostra_cnt_q;
`endif

    // Timeout only accumulates while waiting for a play; it reads zero on entry
    if ((state_q == ESPERA || state_q == ESPERA_NOVA) && !timeout)
      tmo_d = tmo_q + TW'(1);

    case (state_q)
      INICIAL: if (iniciar) state_d = PREPARA;
      PREPARA: begin
        rodada_d   = '0;
        endereco_d = '0;
        jogada_d   = '0;
        for (int i = 0; i < MEM_DEPTH; i++) mem_d[i] = (i == 0) ? 4'b0001 : 4'b0000;
        state_d    = INICIA_RODADA;
      end
      INICIA_RODADA: begin
        endereco_d = '0;
`ifdef SHOW_SEQUENCE_EN
        mostra_cnt_d = '0;
        state_d      = MOSTRA;
`else
        state_d      = ESPERA;
`endif
      end
      ESPERA: begin
        if (pulse_q) begin
          jogada_d = botoes_edge_q;
          state_d  = REGISTRA;
        end else if (timeout) begin
          state_d  = FIM_TIMEOUT;
        end
      end
      REGISTRA: state_d = COMPARA;
      COMPARA: begin
        if (jogada_q != mem_rd)            state_d = FIM_PERDEU;
        else if (endereco_q != rodada_q)   state_d = PROXIMA;
        else if (rodada_q == LAST_ADDR)    state_d = FIM_GANHOU;
        else                               state_d = ESPERA_NOVA;
      end
      PROXIMA: begin
        endereco_d = endereco_q + AW'(1);
        state_d    = ESPERA;
      end
      ESPERA_NOVA: begin
        if (pulse_q) begin
          jogada_d = botoes_edge_q;
          state_d  = REGISTRA_NOVA;
        end else if (timeout) begin
          state_d  = FIM_TIMEOUT;
        end
      end
      REGISTRA_NOVA: begin
        endereco_d = endereco_q + AW'(1);
        state_d    = ESCREVE;
      end
      ESCREVE: begin
        mem_d[endereco_q] = jogada_q;
        state_d           = PROXIMA_RODADA;
      end
      PROXIMA_RODADA: begin
        rodada_d = rodada_q + AW'(1);
        state_d  = INICIA_RODADA;
      end
      FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: if (iniciar) state_d = PREPARA;
`ifdef SHOW_SEQUENCE_EN
      // Each entry: 5 lit cycles then 1 blank cycle
      MOSTRA: begin
        if (mostra_cnt_q == 3'd5) begin
          mostra_cnt_d = '0;
          if (endereco_q == rodada_q) begin
            endereco_d = '0;
            state_d    = ESPERA;
          end else begin
            endereco_d = endereco_q + AW'(1);
          end
        end else begin
          mostra_cnt_d = mostra_cnt_q + 3'd1;
        end
      end
`endif
      default: state_d = INICIAL;
    endcase

    // Flags are computed from the next state so they line up with state_q
    pronto_d = (state_d == FIM_GANHOU) || (state_d == FIM_PERDEU) || (state_d == FIM_TIMEOUT);
    ganhou_d = (state_d == FIM_GANHOU);
    perdeu_d = (state_d == FIM_PERDEU) || (state_d == FIM_TIMEOUT);
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= INICIAL;
      rodada_q      <= '0;
      endereco_q    <= '0;
      jogada_q      <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= (i == 0) ? 4'b0001 : 4'b0000;
      tmo_q         <= '0;
      tem_prev_q    <= 1'b0;
      pulse_q       <= 1'b0;
      botoes_edge_q <= '0;
      pronto_q      <= 1'b0;
      ganhou_q      <= 1'b0;
      perdeu_q      <= 1'b0;
`ifdef SHOW_SEQUENCE_EN
      mostra_cnt_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rodada_q      <= rodada_d;
      endereco_q    <= endereco_d;
      jogada_q      <= jogada_d;
      mem_q         <= mem_d;
      tmo_q         <= tmo_d;
      tem_prev_q    <= tem_prev_d;
      pulse_q       <= pulse_d;
      botoes_edge_q <= botoes_edge_d;
      pronto_q      <= pronto_d;
      ganhou_q      <= ganhou_d;
      perdeu_q      <= perdeu_d;
`ifdef SHOW_SEQUENCE_EN
      mostra_cnt_q  <= mostra_cnt_d;
`endif
    end
  end

`ifdef SHOW_SEQUENCE_EN
  assign leds = (state_q == MOSTRA) ? ((mostra_cnt_q < 3'd5) ? mem_rd : 4'b0000) : jogada_q;
`else
  assign leds = jogada_q;
`endif

  assign pronto                 = pronto_q;
  assign ganhou                 = ganhou_q;
  assign perdeu                 = perdeu_q;
  assign db_clock               = clock;
  assign db_tem_jogada          = tem_jogada;
  assign db_igual               = (jogada_q == mem_rd);
  assign db_enderecoIgualRodada = (endereco_q == rodada_q);
  assign db_timeout             = timeout;

  hex7seg u_seg_contagem (.hex(4'(endereco_q)), .seg(db_contagem));
  hex7seg u_seg_memoria  (.hex(mem_rd),         .seg(db_memoria));
  hex7seg u_seg_jogada   (.hex(jogada_q),       .seg(db_jogadafeita));
  hex7seg u_seg_rodada   (.hex(4'(rodada_q)),   .seg(db_rodada));
  hex7seg u_seg_estado   (.hex(state_q),        .seg(db_estado));
endmodule

// File: tb/tb_circuito_exp6_genius.sv
// tb/tb_circuito_exp6_genius.sv - directed self-checking bench for circuito_exp6_genius

module tb_circuito_exp6_genius;
  localparam int TMO = 200;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic [3:0] botoes = 4'b0000;
  logic [3:0] leds;
  logic       pronto, ganhou, perdeu;
  logic       db_clock, db_tem_jogada, db_igual, db_enderecoIgualRodada, db_timeout;
  logic [6:0] db_contagem, db_memoria, db_jogadafeita, db_rodada, db_estado;

  int checks = 0;
  int errors = 0;
  int tmo_at;
  logic [3:0] seq [16];

  circuito_exp6_genius #(.TIMEOUT_CYCLES(TMO), .MEM_DEPTH(16)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes), .leds(leds),
    .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .db_clock(db_clock),
    .db_tem_jogada(db_tem_jogada), .db_igual(db_igual),
    .db_enderecoIgualRodada(db_enderecoIgualRodada), .db_timeout(db_timeout),
    .db_contagem(db_contagem), .db_memoria(db_memoria), .db_jogadafeita(db_jogadafeita),
    .db_rodada(db_rodada), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 7'h40; 4'h1: seg = 7'h79; 4'h2: seg = 7'h24; 4'h3: seg = 7'h30;
      4'h4: seg = 7'h19; 4'h5: seg = 7'h12; 4'h6: seg = 7'h02; 4'h7: seg = 7'h78;
      4'h8: seg = 7'h00; 4'h9: seg = 7'h10; 4'hA: seg = 7'h08; 4'hB: seg = 7'h03;
      4'hC: seg = 7'h46; 4'hD: seg = 7'h21; 4'hE: seg = 7'h06; default: seg = 7'h0E;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] b, input int hold);
    @(negedge clock);
    botoes = b;
    repeat (hold) @(negedge clock);
    botoes = 4'b0000;
    repeat (8) @(negedge clock);
  endtask

  task automatic start();
    @(negedge clock);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  initial begin
    seq[0] = 4'b0001;
    for (int k = 1; k < 16; k++) seq[k] = 4'b0001 << (k % 4);

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_estado", db_estado, seg(4'h0));
    check("rst_pronto", pronto, 1'b0);
    check("rst_leds", leds, 4'b0000);
    check("rst_mem0", db_memoria, seg(4'h1));
    check("rst_end_eq_rod", db_enderecoIgualRodada, 1'b1);
    reset = 1'b1;

    // Start with iniciar held 10 cycles
    @(negedge clock);
    iniciar = 1'b1;
    repeat (10) @(negedge clock);
    iniciar = 1'b0;
    check("start_estado", db_estado, seg(4'h3));
    check("start_rodada", db_rodada, seg(4'h0));
    check("start_pronto", pronto, 1'b0);
    check("start_leds", leds, 4'b0000);

    // Round 0: long press counts once, then the new play
    press(4'b0001, 10);
    check("r0_espera_nova", db_estado, seg(4'h7));
    check("r0_leds", leds, 4'b0001);
    press(4'b0010, 3);
    check("r1_estado", db_estado, seg(4'h3));
    check("r1_rodada", db_rodada, seg(4'h1));
    check("r1_endereco", db_contagem, seg(4'h0));

    // Round 1: correct first play, wrong second play
    press(4'b0001, 3);
    check("r1_end1", db_contagem, seg(4'h1));
    check("r1_mem1", db_memoria, seg(4'h2));
    check("r1_igual", db_igual, 1'b0);
    press(4'b0100, 3);
    check("lose_estado", db_estado, seg(4'hC));
    check("lose_perdeu", perdeu, 1'b1);
    check("lose_pronto", pronto, 1'b1);
    check("lose_ganhou", ganhou, 1'b0);

    // Restart, then idle until timeout
    @(negedge clock);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("tmo_entry_estado", db_estado, seg(4'h3));
    check("tmo_entry_flag", db_timeout, 1'b0);
    check("tmo_entry_pronto", pronto, 1'b0);
    check("tmo_entry_rodada", db_rodada, seg(4'h0));
    tmo_at = -1;
    for (int i = 1; i <= 2 * TMO; i++) begin
      @(negedge clock);
      if (db_timeout) begin
        tmo_at = i;
        break;
      end
    end
    check("tmo_cycle", tmo_at, TMO - 1);
    @(negedge clock);
    check("tmo_estado", db_estado, seg(4'hD));
    check("tmo_perdeu", perdeu, 1'b1);
    check("tmo_pronto", pronto, 1'b1);
    check("tmo_flag_clear", db_timeout, 1'b0);

    // Full 16-round game
    start();
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i <= r; i++) press(seq[i], 3);
      if (r < 15) begin
        press(seq[r + 1], 3);
        check($sformatf("round%0d_estado", r), db_estado, seg(4'h3));
      end
    end
    check("win_ganhou", ganhou, 1'b1);
    check("win_pronto", pronto, 1'b1);
    check("win_perdeu", perdeu, 1'b0);
    check("win_estado", db_estado, seg(4'hB));
    check("win_rodada", db_rodada, seg(4'hF));
    check("win_endereco", db_contagem, seg(4'hF));
    check("win_mem15", db_memoria, seg(4'h8));

    // Restart from FIM_GANHOU
    @(negedge clock);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    check("restart_estado", db_estado, seg(4'h1));
    check("restart_pronto", pronto, 1'b0);
    check("restart_ganhou", ganhou, 1'b0);
    repeat (2) @(negedge clock);
    check("restart_espera", db_estado, seg(4'h3));
    check("restart_rodada", db_rodada, seg(4'h0));
    check("restart_mem0", db_memoria, seg(4'h1));
    check("restart_leds", leds, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/circuito_exp6_genius.md
Name: circuito_exp6_genius

Overview:
- Top-level "memory game" (Simon-style) unit built from a datapath and a control FSM.
- Each round the player replays the stored sequence of one-hot button plays, then appends one new play to the sequence.
- A full replay of 16 plays wins. A wrong play or an inactivity timeout loses.
- Seven-segment debug outputs expose internal counters and state for the lab board.

Parameters:
- TIMEOUT_CYCLES, 30000: clock cycles allowed without a play before loss (3 s at 10 kHz).
- MEM_DEPTH, 16: sequence length; sets the rodada and endereco widths (4 bits).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- iniciar  in  1  start/restart request, level-sampled
- botoes  in  4  player buttons, one-hot when pressed
- leds  out  4  last registered play
- pronto  out  1  game over (win or loss)
- ganhou  out  1  win flag
- perdeu  out  1  loss flag (wrong play or timeout)
- db_clock  out  1  copy of clock
- db_tem_jogada  out  1  OR of botoes
- db_igual  out  1  registered play equals memory output
- db_enderecoIgualRodada  out  1  endereco == rodada
- db_timeout  out  1  timeout counter expired
- db_contagem  out  7  hex7seg of endereco
- db_memoria  out  7  hex7seg of memory data at endereco
- db_jogadafeita  out  7  hex7seg of registered play
- db_rodada  out  7  hex7seg of rodada
- db_estado  out  7  hex7seg of the 4-bit state code

Behaviour:
- Reset (reset=0, async): FSM to INICIAL (0); all counters, registers and flags cleared; leds=0; memory reloaded with address 0 = 0001, all other addresses 0000.
- Play detection:
  - tem_jogada = |botoes.
  - A rising-edge detector (one-cycle pulse, registered) is the only thing that accepts a play.
  - A button held for many cycles counts as exactly one play.
  - On the pulse, botoes is latched into the jogada register.
- Timeout:
  - The counter runs only in ESPERA and ESPERA_NOVA and clears on entering either state.
  - db_timeout=1 when the count reaches TIMEOUT_CYCLES-1.
- FSM states (code):
  - INICIAL(0): stays until iniciar=1.
  - PREPARA(1): clears rodada, endereco, jogada, timeout; reloads memory defaults.
  - INICIA_RODADA(2): endereco=0.
  - ESPERA(3): waits for the edge pulse (goes to REGISTRA); on timeout goes to FIM_TIMEOUT.
  - REGISTRA(4): jogada latched.
  - COMPARA(5): if jogada differs from mem[endereco], go to FIM_PERDEU. Otherwise:
    - if endereco != rodada, go to PROXIMA.
    - else if rodada == 15, go to FIM_GANHOU.
    - else go to ESPERA_NOVA.
  - PROXIMA(6): endereco+1, then ESPERA.
  - ESPERA_NOVA(7): waits for the edge pulse (goes to REGISTRA_NOVA); timeout goes to FIM_TIMEOUT.
  - REGISTRA_NOVA(8): jogada latched; endereco+1.
  - ESCREVE(9): mem[endereco] <= jogada.
  - PROXIMA_RODADA(A): rodada+1, then INICIA_RODADA.
  - FIM_GANHOU(B), FIM_PERDEU(C), FIM_TIMEOUT(D): pronto=1, with ganhou or perdeu set as appropriate; iniciar=1 goes to PREPARA.
  - Unused codes go to INICIAL.
- Outputs in final states are Moore outputs of the state and are 0 elsewhere.
- Counters are 4-bit with no wrap in normal play: rodada stops at 15; endereco never exceeds rodada+1.
- A play accepted in any state other than ESPERA/ESPERA_NOVA is ignored.
- iniciar held during play has no effect.
- hex7seg encoding is active-low segments, with 0-F on the standard encoding.

Optional Feature:
- Macro SHOW_SEQUENCE_EN.
- Defined: after INICIA_RODADA, a MOSTRA state (E) drives leds with mem[0..rodada]. Each entry is shown for 5 cycles followed by 1 blank cycle, then the FSM enters ESPERA.
- Undefined: the MOSTRA state is absent, and leds show only the registered play.

Test Plan:
- Reset pulse, then iniciar=1 for 10 cycles -> state 3, rodada=0, pronto=0, leds=0000.
- Round 0: press 0001 for 10 cycles, then new play 0010 -> rodada=1, mem[1]=0010, db_estado shows 3.
- Wrong play: in round 1 press 0001, then 0100 at endereco 1 -> state C, perdeu=1, pronto=1, ganhou=0.
- No press for TIMEOUT_CYCLES in ESPERA -> db_timeout pulses, state D, perdeu=1, pronto=1.
- 16 rounds, each replaying the stored sequence correctly and appending new plays -> after the 16th replay: ganhou=1, pronto=1, rodada=15, no write of address 16.
- From FIM_GANHOU, iniciar=1 -> PREPARA, flags cleared, memory back to defaults, rodada=0.
